mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller and arbiter for the toy CPU. It shares one byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM), assembles and splits 1/2/4-byte accesses, and raises stall requests into the pipeline stall vector while an access is outstanding. It sits between the pc/IF stage, the MEM stage and the external RAM.

## Interface
No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  32  fetch address (word aligned)
- jump_flush  in  1  branch/jump taken; abort pending fetch
- mem_req  in  1  MEM access request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, little-endian
- ram_din  in  8  RAM read data (valid the cycle after RAM samples ram_addr)
- ram_addr  out  32  RAM byte address, registered
- ram_dout  out  8  RAM write data, registered
- ram_wr  out  1  RAM write strobe, registered
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word
- mem_done  out  1  one-cycle pulse, load/store complete
- mem_rdata  out  32  load data, zero-extended
- stallreq_if  out  1  if_req && !if_done
- stallreq_mem  out  1  mem_req && !mem_done

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. 3-bit byte counter, 32-bit assembly register.
- IDLE arbitration: mem_req wins over if_req (older instruction). A port whose done is high this cycle is not re-accepted.
- Accept: ram_addr <= base address, counter <= 0. Store also drives ram_dout <= byte0 and ram_wr <= 1.
- Read: ram_addr increments each cycle until the last byte is issued. ram_din is captured little-endian into byte[counter-1].
- Write: one byte per cycle, ram_wr high for exactly N cycles. ram_wr <= 0 on completion.
- Byte count N: 1/2/4 from mem_len; IF always 4.
- jump_flush in IF_RD, or with if_req pending in IDLE: abort, go to IDLE, no if_done, if_inst unchanged.
- jump_flush has no effect on MEM accesses.
- Stores are never aborted except by rst.
- Reset values: all outputs 0, state IDLE, counter 0.
- rst mid-access drops the access immediately with no done pulse.

## Timing
- Accepting edge is E0.
- N-byte read: bytes captured at E2..E(N+1). Done and data registered at E(N+1), visible the following cycle.
- Word fetch or load: done visible after E5.
- N-byte write: ram_wr high in cycles after E0..E(N-1). done registered at E(N).
- Return to IDLE at the done edge. A different port may be accepted on the next edge (one cycle after the done edge).
- Same-port back-to-back costs exactly one idle cycle.
- stall* outputs are combinational and drop in the done cycle, so the pipeline advances at that edge.

## Configuration
- MEM_CTRL_IBUF_EN defined: adds a one-entry instruction buffer (valid, tag = addr[31:2], word), written on every completed fetch.
  - IF hit in IDLE with MEM not requesting: if_done registered at the next edge, no RAM access.
  - Any accepted store with mem_addr[31:2] == tag clears valid.
  - rst clears valid.
- MEM_CTRL_IBUF_EN undefined: no buffer; every fetch goes to RAM.

## Test plan
- Fetch 0x00000010, RAM bytes 13,57,9B,DF -> if_done after E5, if_inst = 0xDF9B5713, ram_wr stays 0.
- if_req and mem_req (load byte 0x103) in the same cycle -> MEM served first, mem_rdata = 0x000000xx. IF accepted one cycle after mem_done, both stalls correct each cycle.
- Store word 0xAABBCCDD to 0x200 -> ram_wr high 4 cycles, addresses 200..203, data DD,CC,BB,AA, mem_done after E4.
- jump_flush during byte 2 of a fetch -> no if_done, IDLE next edge, new if_addr fetched cleanly.
- rst asserted mid-store -> ram_wr and all outputs 0 asynchronously, no done pulse.
- With MEM_CTRL_IBUF_EN: refetch same address -> if_done one edge after request, no RAM access. Store to that word, then refetch -> full 4-byte RAM read.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM port between IF and MEM, 1/2/4-byte accesses.
// Define MEM_CTRL_IBUF_EN to add a one-entry instruction buffer.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        jump_flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic        if_done,
  output logic [31:0] if_inst,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [2:0]  mem_n;
  logic [2:0]  cnt_nx;
  logic [7:0]  wbyte;
  logic        take_mem;
  logic        take_if;
  logic        ibuf_hit;
  logic [31:0] ibuf_word;

`ifdef MEM_CTRL_IBUF_EN
  logic        ibuf_valid;
  logic [29:0] ibuf_tag;
  assign ibuf_hit = ibuf_valid && (ibuf_tag == if_addr[31:2]);
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_word = '0;
`endif

  assign stallreq_if  = if_req && !if_done;
  assign stallreq_mem = mem_req && !mem_done;

  // MEM is the older instruction, so it wins the port
  assign take_mem = mem_req && !mem_done;
  assign take_if  = !take_mem && if_req && !if_done && !jump_flush;
  assign cnt_nx   = cnt + 3'd1;

  always_comb begin
    case (mem_len)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  // byte arriving now belongs to the address issued two edges ago
  always_comb begin
    asm_next = asm_q;
    case (cnt)
      3'd1:    asm_next[7:0]   = ram_din;
      3'd2:    asm_next[15:8]  = ram_din;
      3'd3:    asm_next[23:16] = ram_din;
      3'd4:    asm_next[31:24] = ram_din;
      default: ;
    endcase
  end

  always_comb begin
    case (cnt_nx[1:0])
      2'd1:    wbyte = mem_wdata[15:8];
      2'd2:    wbyte = mem_wdata[23:16];
      2'd3:    wbyte = mem_wdata[31:24];
      default: wbyte = mem_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      asm_q     <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      if_inst   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
`ifdef MEM_CTRL_IBUF_EN
      ibuf_valid <= 1'b0;
      ibuf_tag   <= '0;
      ibuf_word  <= '0;
`endif
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take_mem) begin
            state    <= mem_we ? MEM_WR : MEM_RD;
            ram_addr <= mem_addr;
            cnt      <= '0;
            nbytes   <= mem_n;
            asm_q    <= '0;
            if (mem_we) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
`ifdef MEM_CTRL_IBUF_EN
              if (mem_addr[31:2] == ibuf_tag) ibuf_valid <= 1'b0;
`endif
            end
          end else if (take_if && ibuf_hit) begin
            if_done <= 1'b1;
            if_inst <= ibuf_word;
          end else if (take_if) begin
            state    <= IF_RD;
            ram_addr <= if_addr;
            cnt      <= '0;
            nbytes   <= 3'd4;
            asm_q    <= '0;
          end
        end
        IF_RD, MEM_RD: begin
          if (state == IF_RD && jump_flush) begin
            state <= IDLE;
          end else begin
            asm_q <= asm_next;
            if (cnt == nbytes) begin
              state <= IDLE;
              if (state == IF_RD) begin
                if_done <= 1'b1;
                if_inst <= asm_next;
`ifdef MEM_CTRL_IBUF_EN
                ibuf_valid <= 1'b1;
                ibuf_tag   <= ram_addr[31:2];
                ibuf_word  <= asm_next;
`endif
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= asm_next;
              end
            end else begin
              cnt <= cnt_nx;
              if (cnt_nx < nbytes) ram_addr <= ram_addr + 32'd1;
            end
          end
        end
        MEM_WR: begin
          if (cnt_nx == nbytes) begin
            state    <= IDLE;
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt_nx;
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wbyte;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: vector table, hand sequences and random traffic against a byte-array model.
// Builds with or without MEM_CTRL_IBUF_EN.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, jump_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr, if_inst, mem_rdata;
  logic [7:0]  ram_dout;
  logic        ram_wr, if_done, mem_done, stallreq_if, stallreq_mem;

  int total = 0;
  int bad = 0;

`ifdef MEM_CTRL_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  mem_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .jump_flush(jump_flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .if_done(if_done), .if_inst(if_inst),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  // external RAM: synchronous read, data one cycle after address sampled
  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  // reference model state
  logic [7:0]  mm [0:4095];
  bit          mv;
  logic [29:0] mtag;
  logic [31:0] mword;
  logic [19:0] wlog [$];

  typedef struct {
    int          kind;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model(input int kind, input logic [1:0] len, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d,
                       output int lat, output int wr);
    int n;
    logic [11:0] ix;
    n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    d = '0;
    wr = 0;
    lat = 0;
    if (kind == 0) begin
      if (IBUF && mv && mtag == a[31:2]) begin
        d = mword;
        lat = 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          ix = a[11:0] + 12'(i);
          d[i*8 +: 8] = mm[ix];
        end
        lat = 6;
        mv = 1'b1;
        mtag = a[31:2];
        mword = d;
      end
    end else if (kind == 1) begin
      for (int i = 0; i < n; i++) begin
        ix = a[11:0] + 12'(i);
        d[i*8 +: 8] = mm[ix];
      end
      lat = n + 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        ix = a[11:0] + 12'(i);
        mm[ix] = wd[i*8 +: 8];
      end
      lat = n + 1;
      wr = n;
      if (mtag == a[31:2]) mv = 1'b0;
    end
  endtask

  task automatic txn(input int kind, input logic [1:0] len, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] d,
                     output int lat, output int wr, output int stl);
    @(negedge clk);
    if (kind == 0) begin
      if_req = 1'b1;
      if_addr = a;
    end else begin
      mem_req = 1'b1;
      mem_we = (kind == 2);
      mem_len = len;
      mem_addr = a;
      mem_wdata = wd;
    end
    d = '0;
    lat = 0;
    wr = 0;
    stl = 0;
    wlog.delete();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ram_wr) begin
        wr++;
        wlog.push_back({ram_addr[11:0], ram_dout});
      end
      if (kind == 0 ? stallreq_if : stallreq_mem) stl++;
      if (kind == 0 ? if_done : mem_done) begin
        lat = c;
        d = (kind == 0) ? if_inst : mem_rdata;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
  endtask

  task automatic run_chk(input string nm, input int kind, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input int el, input int ew);
    logic [31:0] d;
    int lat, wr, stl;
    txn(kind, len, a, wd, d, lat, wr, stl);
    if (kind != 2) chk({nm, " data"}, d, ed);
    chk({nm, " latency"}, lat, el);
    chk({nm, " wr cycles"}, wr, ew);
    chk({nm, " stall cycles"}, stl, el - 1);
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a = a;
    pre_d = d;
    mm[a] = d;
  endtask

  initial begin
    logic [31:0] d, e, rd, inst;
    int lat, wr, kind, md, id, sm, si, cnt;
    logic [1:0] len;
    logic [31:0] a, wd;

    rst = 1'b1;
    if_req = 0; if_addr = 0; jump_flush = 0;
    mem_req = 0; mem_we = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;
    pre_we = 0; pre_a = 0; pre_d = 0;
    mv = 1'b0; mtag = '0; mword = '0;

    for (int i = 0; i < 4096; i++) poke(12'(i), 8'h00);
    poke(12'h010, 8'h13);
    poke(12'h011, 8'h57);
    poke(12'h012, 8'h9B);
    poke(12'h013, 8'hDF);
    poke(12'h103, 8'h5A);
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_dout", {24'h0, ram_dout}, 0);
    chk("reset ram_wr", {31'h0, ram_wr}, 0);
    chk("reset if_done", {31'h0, if_done}, 0);
    chk("reset if_inst", if_inst, 0);
    chk("reset mem_done", {31'h0, mem_done}, 0);
    chk("reset mem_rdata", mem_rdata, 0);

    tbl[0] = '{0, 2'd0, 32'h010, 32'h0,        32'hDF9B5713, 6, 0};
    tbl[1] = '{2, 2'd2, 32'h200, 32'hAABBCCDD, 32'h0,        5, 4};
    tbl[2] = '{1, 2'd2, 32'h200, 32'h0,        32'hAABBCCDD, 6, 0};
    tbl[3] = '{1, 2'd1, 32'h201, 32'h0,        32'h0000BBCC, 4, 0};
    tbl[4] = '{1, 2'd0, 32'h203, 32'h0,        32'h000000AA, 3, 0};
    tbl[5] = '{2, 2'd0, 32'h202, 32'h12345655, 32'h0,        2, 1};
    tbl[6] = '{1, 2'd2, 32'h200, 32'h0,        32'hAA55CCDD, 6, 0};
    tbl[7] = '{2, 2'd1, 32'h300, 32'h99997788, 32'h0,        3, 2};
    tbl[8] = '{1, 2'd3, 32'h300, 32'h0,        32'h00007788, 6, 0};
    tbl[9] = '{0, 2'd0, 32'h300, 32'h0,        32'h00007788, 6, 0};

    for (int v = 0; v < 10; v++) begin
      run_chk($sformatf("vec%0d", v), tbl[v].kind, tbl[v].len, tbl[v].addr,
              tbl[v].wdata, tbl[v].exp_data, tbl[v].exp_lat, tbl[v].exp_wr);
      if (v == 1) begin
        chk("store log size", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
          e = {12'h0, 12'h200 + 12'(k), 8'h00};
          e[7:0] = (k == 0) ? 8'hDD : (k == 1) ? 8'hCC : (k == 2) ? 8'hBB : 8'hAA;
          chk($sformatf("store byte%0d", k), {12'h0, wlog[k]}, e);
        end
      end
    end

    // IF and MEM requested together: MEM first, IF one cycle after mem_done
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h010;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h103;
    md = 0; id = 0; sm = 0; si = 0; rd = '0; inst = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (stallreq_mem) sm++;
      if (stallreq_if) si++;
      if (mem_done && md == 0) begin md = c; rd = mem_rdata; mem_req = 1'b0; end
      if (if_done && id == 0) begin id = c; inst = if_inst; if_req = 1'b0; end
      if (md != 0 && id != 0) break;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    chk("arb mem_done cycle", md, 3);
    chk("arb if_done cycle", id, 9);
    chk("arb mem_rdata", rd, 32'h0000005A);
    chk("arb if_inst", inst, 32'hDF9B5713);
    chk("arb stall_mem cycles", sm, 2);
    chk("arb stall_if cycles", si, 8);

    // jump_flush while the second byte of a fetch is in flight
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h020;
    id = 0; inst = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) begin jump_flush = 1'b1; if_addr = 32'h300; end
      if (c == 3) begin
        jump_flush = 1'b0;
        chk("flush if_inst kept", if_inst, 32'hDF9B5713);
      end
      if (if_done && id == 0) begin id = c; inst = if_inst; break; end
    end
    if_req = 1'b0;
    jump_flush = 1'b0;
    chk("flush refetch done cycle", id, 9);
    chk("flush refetch inst", inst, 32'h00007788);

`ifdef MEM_CTRL_IBUF_EN
    a = ram_addr;
    run_chk("ibuf hit", 0, 2'd0, 32'h300, 32'h0, 32'h00007788, 1, 0);
    chk("ibuf hit no ram access", ram_addr, a);
    run_chk("ibuf store", 2, 2'd2, 32'h300, 32'h11223344, 32'h0, 5, 4);
    run_chk("ibuf miss", 0, 2'd0, 32'h300, 32'h0, 32'h11223344, 6, 0);
`endif

    // random traffic in a region the directed tests never touch
    mv = 1'b0;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      len = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (kind == 0) a = 32'h800 + ($urandom_range(0, 7) << 2);
      else if (kind == 2) a = 32'h800 + $urandom_range(0, 63);
      else a = 32'h800 + $urandom_range(0, 255);
      model(kind, len, a, wd, d, lat, wr);
      run_chk($sformatf("rnd%0d k%0d @%h", t, kind, a), kind, len, a, wd, d, lat, wr);
    end

    // reset in the middle of a word store
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h400; mem_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("midstore ram_wr on", {31'h0, ram_wr}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midstore rst ram_wr", {31'h0, ram_wr}, 0);
    chk("midstore rst ram_addr", ram_addr, 0);
    chk("midstore rst ram_dout", {24'h0, ram_dout}, 0);
    chk("midstore rst if_inst", if_inst, 0);
    chk("midstore rst mem_rdata", mem_rdata, 0);
    mem_req = 1'b0;
    mem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_done || ram_wr) cnt++;
    end
    chk("midstore no done or write", cnt, 0);
    run_chk("post reset fetch", 0, 2'd0, 32'h010, 32'h0, 32'hDF9B5713, 6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
